// File: rtl/bcd4decode.sv
// bcd4decode: sequential 4-digit BCD-to-binary converter (Horner, one digit per cycle)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-low reset
//   start  in   conversion request, honoured only while ready
//   A..D   in   BCD digits (A = ones ... D = thousands), captured on the accepting edge
//   value  out  registered binary result (VALUE_W bits)
//   err    out  registered illegal-digit flag of the last conversion
//   ready  out  high while idle
//
// Build option: define BCD_BLANK_EN to accept leading 0xF digits as blanks worth 0.
module bcd4decode #(
    parameter int VALUE_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         A,
    input  logic [3:0]         B,
    input  logic [3:0]         C,
    input  logic [3:0]         D,
    output logic [VALUE_W-1:0] value,
    output logic               err,
    output logic               ready
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_ACCUM = 2'b11,
        S_DONE  = 2'b10
    } state_t;

    state_t             r_state;
    logic [3:0][3:0]    r_dig;
    logic [VALUE_W-1:0] r_acc;
    logic [1:0]         r_idx;
    logic               r_bad;
    logic [3:0]         w_over;
    logic [3:0]         w_eff;
    logic               w_bad;

    always_comb begin
        w_over = '0;
        for (int i = 0; i < 4; i++) w_over[i] = r_dig[i] > 4'd9;
    end

`ifdef BCD_BLANK_EN
    // A digit is a leading blank when it and every more-significant digit are 0xF.
    logic [3:0] w_lead;
    assign w_lead = {&r_dig[3], &r_dig[3:2], &r_dig[3:1], &r_dig};
    assign w_bad  = |(w_over & ~w_lead);
    assign w_eff  = w_lead[r_idx] ? 4'd0 : r_dig[r_idx];
`else
    assign w_bad  = |w_over;
    assign w_eff  = r_dig[r_idx];
`endif

    assign ready = r_state == S_IDLE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_dig   <= {4{4'hF}};
            r_acc   <= '0;
            r_idx   <= 2'd3;
            r_bad   <= 1'b0;
            value   <= '0;
            err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_dig   <= {D, C, B, A};
                    r_acc   <= '0;
                    r_idx   <= 2'd3;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_bad   <= w_bad;
                    r_state <= S_ACCUM;
                end
                S_ACCUM: begin
                    // acc*10 as acc*8 + acc*2
                    r_acc   <= (r_acc << 3) + (r_acc << 1) + VALUE_W'(w_eff);
                    r_idx   <= r_idx - 2'd1;
                    r_state <= r_idx == 2'd0 ? S_DONE : S_ACCUM;
                end
                default: begin
                    value   <= r_bad ? '0 : r_acc;
                    err     <= r_bad;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd4decode.sv
// tb_bcd4decode: directed self-checking bench for bcd4decode
module tb_bcd4decode;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  A, B, C, D;
    logic [13:0] value;
    logic        err;
    logic        ready;
    int          n_chk = 0;
    int          n_pass = 0;

    bcd4decode dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .value (value),
        .err   (err),
        .ready (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic drive(input logic [3:0] d, c, b, a);
        D = d; C = c; B = b; A = a;
        start = 1'b1;
    endtask

    // Called #1 after a rising edge; returns #1 after the result edge k+6.
    task automatic conv(input string tag, input logic [3:0] d, c, b, a,
                        input logic [13:0] ev, input logic ee);
        drive(d, c, b, a);
        @(posedge clk); #1 start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("%s_busy%0d", tag, i), ready, 0);
        end
        @(posedge clk); #1;
        check({tag, "_ready"}, ready, 1);
        check({tag, "_value"}, value, ev);
        check({tag, "_err"}, err, ee);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; {D, C, B, A} = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_value", value, 0);
        check("rst_err", err, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        conv("c1234", 4'd1, 4'd2, 4'd3, 4'd4, 14'd1234, 1'b0);
        conv("c9999", 4'd9, 4'd9, 4'd9, 4'd9, 14'd9999, 1'b0);
        conv("c0000", 4'd0, 4'd0, 4'd0, 4'd0, 14'd0, 1'b0);
        conv("c5a00", 4'd5, 4'hA, 4'd0, 4'd0, 14'd0, 1'b1);
        conv("c0042", 4'd0, 4'd0, 4'd4, 4'd2, 14'd42, 1'b0);
`ifdef BCD_BLANK_EN
        conv("cff42", 4'hF, 4'hF, 4'd4, 4'd2, 14'd42, 1'b0);
        conv("c1000", 4'd1, 4'd0, 4'd0, 4'd0, 14'd1000, 1'b0);
        conv("cffff", 4'hF, 4'hF, 4'hF, 4'hF, 14'd0, 1'b0);
        conv("c1f23", 4'd1, 4'hF, 4'd2, 4'd3, 14'd0, 1'b1);
        conv("cfff7", 4'hF, 4'hF, 4'hF, 4'd7, 14'd7, 1'b0);
        conv("cf9f1", 4'hF, 4'd9, 4'hF, 4'd1, 14'd0, 1'b1);
`else
        conv("cff42", 4'hF, 4'hF, 4'd4, 4'd2, 14'd0, 1'b1);
        conv("c1000", 4'd1, 4'd0, 4'd0, 4'd0, 14'd1000, 1'b0);
        conv("cffff", 4'hF, 4'hF, 4'hF, 4'hF, 14'd0, 1'b1);
        conv("c1f23", 4'd1, 4'hF, 4'd2, 4'd3, 14'd0, 1'b1);
        conv("c000e", 4'd0, 4'd0, 4'd0, 4'hE, 14'd0, 1'b1);
`endif
        conv("c8765", 4'd8, 4'd7, 4'd6, 4'd5, 14'd8765, 1'b0);

        // Second start while busy, with new digits, must be ignored.
        drive(4'd1, 4'd2, 4'd3, 4'd4);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 drive(4'd9, 4'd9, 4'd9, 4'd9);
        @(posedge clk); #1 start = 1'b0;
        check("ign_busy", ready, 0);
        repeat (3) @(posedge clk);
        #1 check("ign_busy5", ready, 0);
        @(posedge clk); #1;
        check("ign_ready", ready, 1);
        check("ign_value", value, 1234);
        check("ign_err", err, 0);
        @(posedge clk); #1;
        check("ign_idle", ready, 1);

        // Reset mid-conversion discards the partial result.
        drive(4'd5, 4'd6, 4'd7, 4'd8);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check("mrst_ready", ready, 1);
        check("mrst_value", value, 0);
        check("mrst_err", err, 0);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mrst_hold_value", value, 0);
        check("mrst_hold_ready", ready, 1);
        conv("c0007", 4'd0, 4'd0, 4'd0, 4'd7, 14'd7, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
